// File: rtl/dev_timer.sv
// Memory-mapped countdown timer: CTRL/PRESET/COUNT word registers on the CPU data port,
// with an IDLE/LOAD/CNT/INT sequencer driving a maskable interrupt flag.
module dev_timer #(
   parameter logic [31:0] BASE_ADDR = 32'h0000_7F00
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   input  logic [3:0]  byteen,
   output logic [31:0] rdata,
   output logic        irq
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_LOAD = 2'd1;
   localparam logic [1:0] S_CNT  = 2'd2;
   localparam logic [1:0] S_INT  = 2'd3;

   localparam logic [1:0] A_CTRL   = 2'd0;
   localparam logic [1:0] A_PRESET = 2'd1;
   localparam logic [1:0] A_COUNT  = 2'd2;

   logic [3:0]  r_ctrl;
   logic [31:0] r_preset;
   logic [31:0] r_count;
   logic [1:0]  r_state;
   logic        r_flag;

   logic        w_hit;
   logic        w_we;
   logic        w_wr_ctrl;
   logic        w_wr_preset;
   logic        w_en;
   logic        w_auto;
   logic [31:0] w_preset_nxt;
   logic        w_unused_addr;

   assign w_hit         = (addr[31:4] == BASE_ADDR[31:4]);
   assign w_we          = w_hit & (|byteen);
   assign w_wr_ctrl     = w_we & (addr[3:2] == A_CTRL);
   assign w_wr_preset   = w_we & (addr[3:2] == A_PRESET);
   assign w_en          = r_ctrl[0];
   // MODE 1x falls back to one-shot, so only 01 reloads
   assign w_auto        = (r_ctrl[2:1] == 2'b01);
   assign w_unused_addr = ^addr[1:0];

   always_comb begin
      w_preset_nxt = r_preset;
      for (int b = 0; b < 4; b++) begin
         if (byteen[b]) w_preset_nxt[8*b +: 8] = wdata[8*b +: 8];
      end
   end

   // The FSM sees pre-edge register values; the CPU write below is applied last so it
   // wins over the FSM clearing EN or the flag on the same edge.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_ctrl   <= 4'd0;
         r_preset <= 32'd0;
         r_count  <= 32'd0;
         r_state  <= S_IDLE;
         r_flag   <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_en) r_state <= S_LOAD;
            end
            S_LOAD: begin
               r_count <= r_preset;
               r_state <= S_CNT;
            end
            S_CNT: begin
               if (!w_en) begin
                  r_state <= S_IDLE;
               end else if (r_count == 32'd0) begin
                  r_state <= S_INT;
                  r_flag  <= 1'b1;
               end else begin
                  r_count <= r_count - 32'd1;
               end
            end
            S_INT: begin
               if (w_auto) begin
                  r_flag  <= 1'b0;
                  r_state <= S_LOAD;
               end else begin
                  r_ctrl[0] <= 1'b0;
                  r_state   <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase

         if (w_wr_ctrl && byteen[0]) r_ctrl <= wdata[3:0];
         if (w_wr_preset) r_preset <= w_preset_nxt;
         if (w_wr_ctrl || w_wr_preset) r_flag <= 1'b0;
      end
   end

   always_comb begin
      rdata = 32'd0;
      if (w_hit) begin
         case (addr[3:2])
            A_CTRL:   rdata = {28'd0, r_ctrl};
            A_PRESET: rdata = r_preset;
            A_COUNT:  rdata = r_count;
            default:  rdata = 32'd0;
         endcase
      end
   end

   assign irq = r_ctrl[3] & r_flag;

endmodule
